// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared FSM states and default widths for the IFM feed path
package acc_pkg;

   localparam int DEF_INPUT_WIDTH  = 512;
   localparam int DEF_OUTPUT_WIDTH = 128;
   localparam int DEF_CNT_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } feed_state_e;

endpackage

// File: rtl/ifm_skid_fifo.sv
// rtl/ifm_skid_fifo.sv - two-entry buffer holding AXIS beats ahead of the parser
// Entry 0 is always the head; a pop shifts entry 1 forward.
module ifm_skid_fifo
   import acc_pkg::*;
#(
   parameter int W = DEF_INPUT_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [1:0]   slot;
   logic         do_push, do_pop;

   assign empty   = (cnt_q == 2'd0);
   assign full    = (cnt_q == 2'd2);
   assign head    = e0_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      slot  = cnt_q - {1'b0, do_pop};
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (do_pop) begin
            e0_d = e1_q;
         end
         // write lands in the first slot left free after any same-cycle pop
         if (do_push) begin
            if (slot == 2'd0) begin
               e0_d = wdata;
            end else begin
               e1_d = wdata;
            end
         end
         cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ifm_feed_ctrl.sv
// rtl/ifm_feed_ctrl.sv - per-tile feed of AXIS beats into the input feature-map parser
// Accepts cfg_beats beats, releases cfg_slices slices, then pulses done.
module ifm_feed_ctrl
   import acc_pkg::*;
#(
   parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   conv_start,
   input  logic [CNT_W-1:0]       cfg_beats,
   input  logic [CNT_W-1:0]       cfg_slices,
   input  logic [INPUT_WIDTH-1:0] s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   output logic [INPUT_WIDTH-1:0] fm,
   output logic                   ifm_read,
   input  logic                   input_req,
   input  logic                   stall_in,
   output logic                   stall,
   output logic                   busy,
   output logic                   done
);

   if (INPUT_WIDTH % OUTPUT_WIDTH != 0) begin : g_width_chk
      $error("INPUT_WIDTH must be a multiple of OUTPUT_WIDTH");
   end

   feed_state_e            state_q, state_d;
   logic [CNT_W-1:0]       beats_q, beats_d;
   logic [CNT_W-1:0]       slices_q, slices_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]       slice_cnt_q, slice_cnt_d;
   logic [INPUT_WIDTH-1:0] fifo_head;
   logic                   fifo_full, fifo_empty;
   logic                   push, pop, flush;
   logic                   advance, last_slice, filling;

   assign filling    = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign s_tready   = filling && (beat_cnt_q < beats_q) && !fifo_full;
   assign push       = s_tvalid & s_tready;
   assign ifm_read   = (state_q == ST_RUN);
   assign stall      = stall_in | (ifm_read & fifo_empty);
   assign advance    = ifm_read & ~stall;
   assign pop        = input_req & advance;
   assign last_slice = (slice_cnt_q == slices_q - CNT_W'(1));
   assign fm         = fifo_empty ? '0 : fifo_head;
   assign busy       = (state_q != ST_IDLE);

   ifm_skid_fifo #(
      .W (INPUT_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (s_tdata),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      slices_d    = slices_q;
      beat_cnt_d  = beat_cnt_q;
      slice_cnt_d = slice_cnt_q;
      flush       = 1'b0;
      done        = 1'b0;
      if (push) begin
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
      if (advance) begin
         slice_cnt_d = slice_cnt_q + CNT_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (conv_start) begin
               beats_d  = cfg_beats;
               slices_d = cfg_slices;
               state_d  = (cfg_slices == '0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (!fifo_empty) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (advance && last_slice) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // leftover beats are dropped so the next tile starts empty
            done        = 1'b1;
            flush       = 1'b1;
            beat_cnt_d  = '0;
            slice_cnt_d = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beats_q     <= '0;
         slices_q    <= '0;
         beat_cnt_q  <= '0;
         slice_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         slices_q    <= slices_d;
         beat_cnt_q  <= beat_cnt_d;
         slice_cnt_q <= slice_cnt_d;
      end
   end

endmodule

// File: tb/tb_ifm_feed_ctrl.sv
// tb/tb_ifm_feed_ctrl.sv - scoreboard bench for ifm_feed_ctrl with a tile-level reference model
module tb_ifm_feed_ctrl;

   localparam int IW = 512;
   localparam int OW = 128;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          conv_start = 1'b0;
   logic [CW-1:0] cfg_beats = '0;
   logic [CW-1:0] cfg_slices = '0;
   logic [IW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          input_req = 1'b0;
   logic          stall_in = 1'b0;
   logic          s_tready, ifm_read, stall, busy, done;
   logic [IW-1:0] fm;

   int checks = 0;
   int errors = 0;

   logic [IW-1:0] beat_data[$];
   logic [IW-1:0] exp_q[$];
   bit            req_mask[$];

   // reference model of the tile, owned by the monitor
   bit m_active, m_run, m_done_now;
   int m_acc, m_pops, m_adv, m_cfg_b, m_cfg_s;
   int done_cnt = 0;
   int uf_stalls = 0;

   always #5 clk = ~clk;

   ifm_feed_ctrl #(
      .INPUT_WIDTH  (IW),
      .OUTPUT_WIDTH (OW),
      .CNT_W        (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .conv_start (conv_start),
      .cfg_beats  (cfg_beats),
      .cfg_slices (cfg_slices),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .fm         (fm),
      .ifm_read   (ifm_read),
      .input_req  (input_req),
      .stall_in   (stall_in),
      .stall      (stall),
      .busy       (busy),
      .done       (done)
   );

   task automatic note_fail(input string name, input string act, input string exp);
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%s required=%s", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) note_fail(name, $sformatf("%b", act), $sformatf("%b", exp));
   endtask

   task automatic chkw(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act !== exp) note_fail(name, $sformatf("%0h", act), $sformatf("%0h", exp));
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) note_fail(name, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   function automatic logic [IW-1:0] rnd_word();
      logic [IW-1:0] w;
      for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   always @(negedge clk) begin : monitor
      int occ;
      bit tr_e, st_e, adv_e, fin, idle;
      if (rst) begin
         m_active = 0; m_run = 0; m_done_now = 0;
         m_acc = 0; m_pops = 0; m_adv = 0; m_cfg_b = 0; m_cfg_s = 0;
         exp_q.delete();
      end
      occ   = m_acc - m_pops;
      tr_e  = m_active && (m_acc < m_cfg_b) && (occ < 2);
      st_e  = stall_in || (m_run && occ == 0);
      adv_e = m_run && !st_e;
      chk1("s_tready", s_tready, tr_e);
      chk1("ifm_read", ifm_read, m_run);
      chk1("stall", stall, st_e);
      chk1("busy", busy, m_active || m_done_now);
      chk1("done", done, m_done_now);
      if (occ == 0) chkw("fm_empty", fm, '0);
      if (adv_e) begin
         if (exp_q.size() == 0) begin
            checks++;
            note_fail("slice_extra", "advance", "no advance");
         end else begin
            chkw("fm_slice", fm, exp_q.pop_front());
         end
      end
      if (done) done_cnt++;
      if (m_run && occ == 0) uf_stalls++;
      if (!rst) begin
         idle = !m_active && !m_done_now;
         fin  = adv_e && (m_adv == m_cfg_s - 1);
         if (s_tvalid && tr_e) m_acc++;
         if (adv_e && input_req) m_pops++;
         if (adv_e) m_adv++;
         if (m_done_now) begin
            m_done_now = 0; m_acc = 0; m_pops = 0; m_adv = 0;
         end else if (fin) begin
            m_done_now = 1; m_active = 0; m_run = 0;
         end else if (idle && conv_start) begin
            m_cfg_b = int'(cfg_beats);
            m_cfg_s = int'(cfg_slices);
            if (cfg_slices == '0) m_done_now = 1;
            else m_active = 1;
         end else if (m_active && occ > 0) begin
            m_run = 1;
         end
      end
   end

   // b<0 picks cfg_beats from the request pattern plus up to two spare beats
   task automatic run_tile(input int b_in, input int s, input int per, input int pct,
                           input int gapb, input int gapn, input int stall_at,
                           input int stall_pct, input int cs_at, input int rst_at);
      int b, need, npop, d0, gap_left, stall_left, cyc;
      bit stall_used, cs_used, aborted;
      req_mask.delete();
      beat_data.delete();
      for (int k = 0; k < s; k++)
         req_mask.push_back(per > 0 ? ((k % per) == per - 1) : ($urandom_range(2) == 0));
      need = 1;
      for (int k = 0; k < s - 1; k++) if (req_mask[k]) need++;
      b = (b_in < 0) ? need + int'($urandom_range(2)) : b_in;
      for (int i = 0; i < b + 2; i++) beat_data.push_back(rnd_word());
      npop = 0;
      for (int k = 0; k < s; k++) begin
         exp_q.push_back(beat_data[npop]);
         if (req_mask[k]) npop++;
      end
      d0 = done_cnt; gap_left = gapn; stall_left = 0;
      stall_used = 0; cs_used = 0; aborted = 0;
      @(posedge clk); #1;
      conv_start = 1'b1;
      cfg_beats  = CW'(b);
      cfg_slices = CW'(s);
      for (cyc = 0; cyc < 3000; cyc++) begin
         if (m_acc == gapb && gap_left > 0) begin
            s_tvalid = 1'b0;
            gap_left--;
         end else begin
            s_tvalid = ($urandom_range(99) < pct);
         end
         s_tdata   = (m_acc < beat_data.size()) ? beat_data[m_acc] : '0;
         input_req = (m_adv < s) ? req_mask[m_adv] : 1'($urandom_range(1));
         if (stall_left > 0) begin
            stall_in = 1'b1;
            stall_left--;
         end else if (!stall_used && m_run && m_adv == stall_at) begin
            stall_used = 1; stall_in = 1'b1; stall_left = 4;
         end else begin
            stall_in = ($urandom_range(99) < stall_pct);
         end
         if (!cs_used && m_run && m_adv == cs_at) begin
            cs_used = 1; conv_start = 1'b1;
            cfg_beats = CW'($urandom_range(1, 9));
            cfg_slices = CW'($urandom_range(1, 9));
         end
         if (m_run && m_adv == rst_at) begin
            rst = 1'b1;
            aborted = 1;
         end
         @(posedge clk); #1;
         conv_start = 1'b0;
         if (aborted) begin
            rst = 1'b0;
            break;
         end
         if (done_cnt != d0) break;
      end
      s_tvalid = 1'b0; stall_in = 1'b0; input_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (aborted) begin
         chki("abort_no_done", done_cnt - d0, 0);
      end else begin
         chki("done_pulses", done_cnt - d0, 1);
         chki("slices_left", exp_q.size(), 0);
      end
      exp_q.delete();
   endtask

   initial begin
      int uf0;
      rst = 1'b1;
      stall_in = 1'b1;
      @(posedge clk); #1;
      stall_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // nominal: 3 beats, 12 slices, request every 4th slice
      run_tile(3, 12, 4, 100, -1, 0, -1, 0, -1, -1);
      // underflow: second beat held back 10 cycles
      uf0 = uf_stalls;
      run_tile(2, 8, 4, 100, 1, 10, -1, 0, -1, -1);
      chk1("underflow_stall_seen", (uf_stalls - uf0) > 0, 1'b1);
      // backpressure: stall_in held 5 cycles from slice 3
      run_tile(6, 12, 2, 100, -1, 0, 3, 0, -1, -1);
      // zero slices, then spare beats flushed at DONE, then a clean tile
      run_tile(3, 0, 4, 100, -1, 0, -1, 0, -1, -1);
      run_tile(4, 4, 4, 100, -1, 0, -1, 0, -1, -1);
      run_tile(3, 12, 4, 100, -1, 0, -1, 0, -1, -1);
      // reset at slice 5, then a fresh tile
      run_tile(3, 12, 4, 100, -1, 0, -1, 0, -1, 5);
      run_tile(3, 12, 4, 100, -1, 0, -1, 0, -1, -1);
      // conv_start during RUN is ignored
      run_tile(3, 12, 4, 100, -1, 0, -1, 0, 6, -1);
      for (int t = 0; t < 10; t++)
         run_tile(-1, $urandom_range(1, 10), 0, $urandom_range(40, 100), -1, 0,
                  $urandom_range(0, 8), 10, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifm_feed_ctrl.md
IFM_FEED_CTRL -- requirements
Module: ifm_feed_ctrl

Interface
REQ-001 Parameters SHALL be: INPUT_WIDTH, default 512, AXIS beat width; OUTPUT_WIDTH, default 128, parser slice width; CNT_W, default 16, beat/slice counter width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 conv_start  in  1  one-cycle pulse that starts a tile; honoured only in IDLE.
REQ-005 cfg_beats  in  CNT_W  INPUT_WIDTH beats to accept for the tile; sampled on conv_start.
REQ-006 cfg_slices  in  CNT_W  parser slices to release for the tile; sampled on conv_start.
REQ-007 s_tdata  in  INPUT_WIDTH  AXIS data; s_tvalid in 1; s_tready out 1.
REQ-008 fm  out  INPUT_WIDTH  head buffer word driven to the parser.
REQ-009 ifm_read  out  1  parser enable.
REQ-010 input_req  in  1  parser request: head word consumed at end of current slice.
REQ-011 stall_in  in  1  downstream PE-array stall.
REQ-012 stall  out  1  parser stall.
REQ-013 busy  out  1  high in any state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, FILL, RUN, DONE.
REQ-015 IDLE->FILL on conv_start when cfg_slices!=0; IDLE->DONE on conv_start when cfg_slices==0.
REQ-016 FILL->RUN on the first cycle the head buffer entry is valid.
REQ-017 RUN->DONE on the cycle the final slice advances (advance while slice_cnt==cfg_slices-1).
REQ-018 DONE SHALL last exactly one cycle, assert done, flush both buffer entries, clear counters, then go to IDLE.
REQ-019 Buffering SHALL be a 2-entry FIFO; s_tready = (beat_cnt<cfg_beats) & (FIFO not full) & state in {FILL,RUN}.
REQ-020 A beat is accepted when s_tvalid&s_tready; beat_cnt increments by 1 per accepted beat.
REQ-021 fm SHALL equal the FIFO head word; fm SHALL be 0 when the FIFO is empty.
REQ-022 ifm_read SHALL be 1 exactly in RUN.
REQ-023 stall = stall_in | (ifm_read & FIFO empty), combinational.
REQ-024 advance = ifm_read & ~stall; slice_cnt increments by 1 per advance.
REQ-025 Pop = input_req & advance; the popped word is replaced at the head by the second entry in the next cycle; if none, the next cycle stalls until a beat arrives.
REQ-026 Push and pop in the same cycle SHALL keep occupancy constant and preserve order.
REQ-027 Latency: a beat accepted in cycle N SHALL appear on fm in N+1 when the FIFO was empty; ifm_read rises the cycle after entering RUN.
REQ-028 Extra beats beyond slice demand SHALL be discarded at DONE; beats beyond cfg_beats SHALL NOT be accepted (s_tready=0).
REQ-029 Counter comparisons SHALL be unsigned at CNT_W bits; counters SHALL NOT wrap within a tile.
REQ-030 conv_start outside IDLE SHALL be ignored.

Reset
REQ-031 While rst=1: state=IDLE, FIFO empty, counters=0, cfg regs=0; outputs s_tready=0, ifm_read=0, busy=0, done=0, fm=0, stall=stall_in.
REQ-032 rst asserted mid-tile SHALL abort immediately with no done pulse; the next tile after release SHALL behave as from a cold start.

Structure
REQ-033 Shared package acc_pkg SHALL hold the FSM state enumeration and the default INPUT_WIDTH/OUTPUT_WIDTH/CNT_W constants.
REQ-034 The 2-entry buffer SHALL be the sub-module ifm_skid_fifo (push, pop, flush, head, full, empty); the FSM and counters stay in ifm_feed_ctrl.

Verification
REQ-035 Nominal: cfg_beats=3, cfg_slices=12, s_tvalid constantly 1, parser model requests every 4th slice -> 12 consecutive advances, fm=beat0,1,2 in order, one done pulse, busy low after.
REQ-036 Underflow: cfg_beats=2, cfg_slices=8, second beat delayed 10 cycles -> stall=1 from slice 4 until the beat is accepted, no slice lost, fm=beat1 on resume.
REQ-037 Backpressure: stall_in held high 5 cycles mid-tile -> slice_cnt frozen, no pop, s_tready=0 once the FIFO is full.
REQ-038 Zero/extra: cfg_slices=0 -> done in the cycle after conv_start with no beats accepted; cfg_beats=4, cfg_slices=4 -> FIFO flushed at DONE and the next tile starts empty.
REQ-039 Reset mid-RUN: rst pulsed at slice 5 of 12 -> all outputs reset, no done; a fresh tile then completes correctly.
REQ-040 conv_start pulsed during RUN -> ignored; cfg values unchanged.
